// File: rtl/gf_pkg.sv
// Shared GF(2^M) definitions: direction codes, default field, build FSM states
// and the alpha-step function reused by the Chien-search stage.
package gf_pkg;

  localparam int                    GF_M_DEFAULT         = 8;
  localparam logic [GF_M_DEFAULT:0] GF_PRIM_POLY_DEFAULT = 9'h11D;
  localparam int                    GF_M_MAX             = 16;

  localparam logic GF_MODE_LOG  = 1'b0;
  localparam logic GF_MODE_ALOG = 1'b1;

  typedef enum logic [1:0] {
    GF_FILL  = 2'd0,
    GF_FIXUP = 2'd1,
    GF_READY = 2'd2
  } gf_state_e;

  // Multiply by alpha for any M up to GF_M_MAX. The top set bit of poly is bit M,
  // so XORing poly lowers the value exactly when the shifted value has bit M set.
  function automatic logic [GF_M_MAX-1:0] gf_alpha_step(input logic [GF_M_MAX-1:0] value,
                                                        input logic [GF_M_MAX:0]   poly);
    logic [GF_M_MAX:0] shifted;
    shifted = {value, 1'b0};
    if ((shifted ^ poly) < shifted) begin
      shifted = shifted ^ poly;
    end
    return shifted[GF_M_MAX-1:0];
  endfunction

endpackage

// File: rtl/gf_alpha_lfsr.sv
// M-bit alpha register for the table build: reset/load to 1, multiply by alpha
// on step_en.
module gf_alpha_lfsr
  import gf_pkg::*;
#(
  parameter int         M         = GF_M_DEFAULT,
  parameter logic [M:0] PRIM_POLY = GF_PRIM_POLY_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step_en,
  output logic [M-1:0] alpha
);

  logic [M-1:0] alpha_reg;
  logic [M-1:0] alpha_next;

  always_comb begin
    alpha_next = alpha_reg;
    if (load) begin
      alpha_next = M'(1);
    end else if (step_en) begin
      alpha_next = M'(gf_alpha_step(GF_M_MAX'(alpha_reg), (GF_M_MAX+1)'(PRIM_POLY)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alpha_reg <= M'(1);
    end else begin
      alpha_reg <= alpha_next;
    end
  end

  assign alpha = alpha_reg;

endmodule

// File: rtl/gf_log_antilog_table.sv
// Self-building GF(2^M) log/antilog tables with NUM_CH independent 1-cycle read
// channels. Optional macro GF_ZERO_FLAG_EN adds the rsp_zero log-of-zero flag.
module gf_log_antilog_table
  import gf_pkg::*;
#(
  parameter int         M         = GF_M_DEFAULT,
  parameter logic [M:0] PRIM_POLY = GF_PRIM_POLY_DEFAULT,
  parameter int         NUM_CH    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ready,
  input  logic [NUM_CH-1:0]   req_valid,
  input  logic [NUM_CH-1:0]   req_mode,
  input  logic [NUM_CH*M-1:0] req_addr,
  output logic [NUM_CH-1:0]   rsp_valid,
  output logic [NUM_CH*M-1:0] rsp_data
`ifdef GF_ZERO_FLAG_EN
  ,
  output logic [NUM_CH-1:0]   rsp_zero
`endif
);

  localparam int           DEPTH    = 1 << M;
  localparam logic [M-1:0] ALL_ONES = {M{1'b1}};
  localparam logic [M-1:0] LAST_IDX = {{(M-1){1'b1}}, 1'b0};

  gf_state_e    state_reg, state_next;
  logic [M-1:0] idx_reg;
  logic [M-1:0] alpha;

  logic [M-1:0] log_mem  [DEPTH];
  logic [M-1:0] alog_mem [DEPTH];

  logic         log_we, alog_we;
  logic [M-1:0] log_waddr, log_wdata, alog_waddr, alog_wdata;

  gf_alpha_lfsr #(
    .M         (M),
    .PRIM_POLY (PRIM_POLY)
  ) u_alpha (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state_reg != GF_FILL),
    .step_en (state_reg == GF_FILL),
    .alpha   (alpha)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= GF_FILL;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == GF_FILL) begin
        idx_reg <= idx_reg + M'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      GF_FILL:  if (idx_reg == LAST_IDX) state_next = GF_FIXUP;
      GF_FIXUP: state_next = GF_READY;
      default:  state_next = GF_READY;
    endcase
  end

  // FIXUP reuses the single write port of each table for the two closing entries.
  always_comb begin
    ready      = (state_reg == GF_READY);
    log_we     = (state_reg != GF_READY);
    alog_we    = (state_reg != GF_READY);
    log_waddr  = alpha;
    log_wdata  = idx_reg;
    alog_waddr = idx_reg;
    alog_wdata = alpha;
    if (state_reg != GF_FILL) begin
      log_waddr  = '0;
      log_wdata  = ALL_ONES;
      alog_waddr = ALL_ONES;
      alog_wdata = M'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (log_we) begin
      log_mem[log_waddr] <= log_wdata;
    end
    if (alog_we) begin
      alog_mem[alog_waddr] <= alog_wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic         accept;
      logic [M-1:0] addr;
      logic         valid_reg;
      logic [M-1:0] data_reg;

      assign accept = ready && req_valid[gi];
      assign addr   = req_addr[gi*M +: M];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= accept;
          if (accept) begin
            data_reg <= (req_mode[gi] == GF_MODE_ALOG) ? alog_mem[addr] : log_mem[addr];
          end
        end
      end

      assign rsp_valid[gi]         = valid_reg;
      assign rsp_data[gi*M +: M]   = data_reg;

`ifdef GF_ZERO_FLAG_EN
      logic zero_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          zero_reg <= 1'b0;
        end else begin
          zero_reg <= accept && (req_mode[gi] == GF_MODE_LOG) && (addr == '0);
        end
      end
      assign rsp_zero[gi] = zero_reg;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_gf_log_antilog_table.sv
// Directed bench for gf_log_antilog_table: build timing (M=8 and M=4), log and
// antilog reads, zero/independence, early requests and mid-operation reset.
module tb_gf_log_antilog_table;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_mode = '0;
  logic [15:0] req_addr = '0;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_data;
`ifdef GF_ZERO_FLAG_EN
  logic [1:0]  rsp_zero;
`endif

  logic        ready4;
  logic [1:0]  req_valid4 = '0;
  logic [1:0]  req_mode4 = '0;
  logic [7:0]  req_addr4 = '0;
  logic [1:0]  rsp_valid4;
  logic [7:0]  rsp_data4;
`ifdef GF_ZERO_FLAG_EN
  logic [1:0]  rsp_zero4;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  gf_log_antilog_table #(.M(8), .PRIM_POLY(9'h11D), .NUM_CH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ready     (ready),
    .req_valid (req_valid),
    .req_mode  (req_mode),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
`ifdef GF_ZERO_FLAG_EN
    ,
    .rsp_zero  (rsp_zero)
`endif
  );

  gf_log_antilog_table #(.M(4), .PRIM_POLY(5'h13), .NUM_CH(2)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ready     (ready4),
    .req_valid (req_valid4),
    .req_mode  (req_mode4),
    .req_addr  (req_addr4),
    .rsp_valid (rsp_valid4),
    .rsp_data  (rsp_data4)
`ifdef GF_ZERO_FLAG_EN
    ,
    .rsp_zero  (rsp_zero4)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    req_valid = 2'b11;
    req_mode  = 2'b10;
    req_addr  = 16'h0000;
    repeat (3) tick();
    vec_cnt++;
    if (ready !== 1'b0 || ready4 !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_ready: got %b/%b want 0/0", ready, ready4);
    end
    vec_cnt++;
    if (rsp_valid !== 2'b00 || rsp_data !== 16'h0000) begin
      err_cnt++;
      $display("FAIL reset_rsp: valid=%b data=%h want 00/0000", rsp_valid, rsp_data);
    end
`ifdef GF_ZERO_FLAG_EN
    vec_cnt++;
    if (rsp_zero !== 2'b00) begin
      err_cnt++;
      $display("FAIL reset_zero: got %b want 00", rsp_zero);
    end
`endif
    $display("reset: ready=%b rsp_valid=%b rsp_data=%h", ready, rsp_valid, rsp_data);
  endtask

  // Requests stay asserted on all channels from release to observe the drop window.
  task automatic test_build_and_early;
    int ready_edge  = 0;
    int ready4_edge = 0;
    int valid_edge  = 0;
    rst_n = 1'b1;
    for (int cnt = 1; cnt <= 260; cnt++) begin
      tick();
      if (ready && ready_edge == 0) ready_edge = cnt;
      if (ready4 && ready4_edge == 0) ready4_edge = cnt;
      if (rsp_valid != 2'b00 && valid_edge == 0) valid_edge = cnt;
    end
    vec_cnt++;
    if (ready_edge != 256) begin
      err_cnt++;
      $display("FAIL build_m8: ready after edge %0d want 256", ready_edge);
    end
    vec_cnt++;
    if (ready4_edge != 16) begin
      err_cnt++;
      $display("FAIL build_m4: ready after edge %0d want 16", ready4_edge);
    end
    vec_cnt++;
    if (valid_edge != 257) begin
      err_cnt++;
      $display("FAIL early_req: first rsp_valid after edge %0d want 257", valid_edge);
    end
    $display("build: m8 ready@%0d m4 ready@%0d first rsp@%0d", ready_edge, ready4_edge, valid_edge);
    req_valid = 2'b00;
    tick();
  endtask

  // Back-to-back log reads on channel 0, then a hold check with no request.
  task automatic test_log;
    logic [7:0] addrs [5] = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd255};
    logic [7:0] exps  [5] = '{8'd0, 8'd1, 8'd25, 8'd198, 8'd175};
    req_valid = 2'b01;
    req_mode  = 2'b00;
    for (int i = 0; i < 5; i++) begin
      req_addr = {8'h00, addrs[i]};
      tick();
      vec_cnt++;
      if (rsp_valid !== 2'b01 || rsp_data[7:0] !== exps[i]) begin
        err_cnt++;
        $display("FAIL log_%0d: valid=%b data=%0d want 01/%0d", addrs[i], rsp_valid, rsp_data[7:0], exps[i]);
      end
      $display("log(%0d) -> %0d", addrs[i], rsp_data[7:0]);
    end
    req_valid = 2'b00;
    tick();
    vec_cnt++;
    if (rsp_valid !== 2'b00 || rsp_data[7:0] !== 8'd175) begin
      err_cnt++;
      $display("FAIL log_hold: valid=%b data=%0d want 00/175", rsp_valid, rsp_data[7:0]);
    end
  endtask

  task automatic test_alog;
    logic [7:0] addrs [5] = '{8'd0, 8'd1, 8'd8, 8'd25, 8'd255};
    logic [7:0] exps  [5] = '{8'd1, 8'd2, 8'd29, 8'd3, 8'd1};
    req_valid = 2'b10;
    req_mode  = 2'b10;
    for (int i = 0; i < 5; i++) begin
      req_addr = {addrs[i], 8'h00};
      tick();
      vec_cnt++;
      if (rsp_valid !== 2'b10 || rsp_data[15:8] !== exps[i]) begin
        err_cnt++;
        $display("FAIL alog_%0d: valid=%b data=%0d want 10/%0d", addrs[i], rsp_valid, rsp_data[15:8], exps[i]);
      end
      $display("alog(%0d) -> %0d", addrs[i], rsp_data[15:8]);
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_zero;
    req_valid = 2'b11;
    req_mode  = 2'b10;
    req_addr  = 16'h0000;
    tick();
    req_valid = 2'b00;
    vec_cnt++;
    if (rsp_valid !== 2'b11 || rsp_data !== 16'h01FF) begin
      err_cnt++;
      $display("FAIL zero_indep: valid=%b data=%h want 11/01ff", rsp_valid, rsp_data);
    end
`ifdef GF_ZERO_FLAG_EN
    vec_cnt++;
    if (rsp_zero !== 2'b01) begin
      err_cnt++;
      $display("FAIL zero_flag: got %b want 01", rsp_zero);
    end
`endif
    $display("zero: ch0 log(0)=%0d ch1 alog(0)=%0d", rsp_data[7:0], rsp_data[15:8]);
    tick();
  endtask

  task automatic test_mid_reset;
    int rebuild = 0;
    int k_fail  = 0;
    logic [7:0] v;
    req_valid = 2'b11;
    req_mode  = 2'b01;
    for (int i = 0; i < 5; i++) begin
      req_addr = {8'(i + 3), 8'(i + 1)};
      tick();
    end
    vec_cnt++;
    if (rsp_valid !== 2'b11 || ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL stream_pre: valid=%b ready=%b want 11/1", rsp_valid, ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (rsp_valid !== 2'b00 || ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL async_reset: valid=%b ready=%b want 00/0", rsp_valid, ready);
    end
    req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    for (int cnt = 1; cnt <= 400 && rebuild == 0; cnt++) begin
      tick();
      if (ready) rebuild = cnt;
    end
    vec_cnt++;
    if (rebuild != 256) begin
      err_cnt++;
      $display("FAIL rebuild: ready after edge %0d want 256", rebuild);
    end
    $display("rebuild: ready after %0d edges", rebuild);
    tick();
    for (int k = 0; k < 255; k++) begin
      req_valid = 2'b10;
      req_mode  = 2'b10;
      req_addr  = {8'(k), 8'h00};
      tick();
      v = rsp_data[15:8];
      req_valid = 2'b01;
      req_mode  = 2'b00;
      req_addr  = {8'h00, v};
      tick();
      vec_cnt++;
      if (rsp_valid !== 2'b01 || rsp_data[7:0] !== 8'(k)) begin
        err_cnt++;
        k_fail++;
        $display("FAIL sweep_%0d: log(alog)=%0d valid=%b want %0d", k, rsp_data[7:0], rsp_valid, k);
      end
    end
    req_valid = 2'b00;
    $display("sweep: log(alog(k))=k for k=0..254, %0d bad", k_fail);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_build_and_early();
    test_log();
    test_alog();
    test_zero();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/gf_log_antilog_table.md
# gf_log_antilog_table

Parametrised GF(2^M) conversion engine for the Reed-Solomon decoder. It provides both the log direction (decimal to power domain) and the antilog direction (power to decimal domain), with NUM_CH independent read channels. The tables are not hardcoded: after reset, an init state machine builds them by stepping alpha through the field defined by PRIM_POLY. It replaces fixed 8-bit single-direction lookup ROMs in the syndrome, Chien-search and Forney stages.

## Interface
- M, default 8: field width; data, address and exponent width.
- PRIM_POLY, default 9'h11D: primitive polynomial, M+1 bits, bit M set.
- NUM_CH, default 2: number of parallel read channels.
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ready  out  1  tables built; requests are accepted only while high.
- req_valid  in  NUM_CH  per-channel request strobe.
- req_mode  in  NUM_CH  per-channel direction: 0 = log (value in, exponent out), 1 = antilog (exponent in, value out).
- req_addr  in  NUM_CH*M  channel c in bits [c*M +: M].
- rsp_valid  out  NUM_CH  response strobe.
- rsp_data  out  NUM_CH*M  channel c in bits [c*M +: M].
- rsp_zero  out  NUM_CH  present only with GF_ZERO_FLAG_EN.

## Operation
- Storage: two arrays, log_mem and alog_mem, each with 2^M entries of M bits. Each has one internal write port and NUM_CH read ports.
- FSM states are FILL, FIXUP and READY. Reset forces FILL with i = 0 and alpha = 1.
- FILL, one entry per cycle:
  - write alog_mem[i] = alpha and log_mem[alpha] = i;
  - update alpha = (alpha << 1) XOR (alpha[M-1] ? PRIM_POLY[M-1:0] : 0);
  - increment i;
  - after the write with i = 2^M-2, go to FIXUP.
- FIXUP, one cycle:
  - write log_mem[0] = 2^M-1 (the "log of zero" marker);
  - write alog_mem[2^M-1] = 1, since alpha^(2^M-1) = alpha^0;
  - go to READY.
- READY is terminal. Only reset leaves it.
- Reads:
  - While ready = 1 and req_valid[c] = 1, channel c returns log_mem[addr] (mode 0) or alog_mem[addr] (mode 1).
  - Channels are fully independent. Any mix of modes and equal addresses is legal in the same cycle.
- Requests made while ready = 0 are dropped. No response is produced and nothing is queued.
- No back-pressure: a channel accepts one request every cycle.
- An alpha step is arithmetic mod 2: XOR only, no carries. The exponent counter i is M bits and never wraps during FILL.

## Timing
- Reset values: ready = 0, rsp_valid = 0, rsp_data = 0, rsp_zero = 0. The FSM is in FILL.
- Build time: exactly 2^M clock edges after rst_n rises (2^M-1 in FILL, 1 in FIXUP). ready goes high from the edge that leaves FIXUP; for M = 8 that is edge 256.
- Read latency is 1 cycle: a request sampled at edge n produces rsp_valid and rsp_data after edge n.
- rsp_data holds its last value when rsp_valid = 0.
- A request sampled on the same edge that raises ready is dropped. The first accepted request is on the following edge.
- Reset asserted mid-FILL or mid-READY, asynchronously:
  - ready, rsp_valid and rsp_zero clear immediately;
  - the build restarts from i = 0 after release;
  - a response in flight is lost.
- Table contents are not cleared by reset; they are fully rewritten by the next FILL.

## Configuration
- GF_ZERO_FLAG_EN:
  - Defined: adds the rsp_zero port. rsp_zero[c] is high with rsp_valid[c] when the request was mode 0 with addr = 0. rsp_data still returns 2^M-1.
  - Undefined: the port and its logic are absent, and log(0) is distinguishable only as 2^M-1.
  - Antilog requests never raise rsp_zero.

## Structure
- Shared package gf_pkg holds:
  - GF_MODE_LOG and GF_MODE_ALOG constants;
  - default M and PRIM_POLY localparams;
  - the FSM state typedef (FILL, FIXUP, READY);
  - function gf_alpha_step(value, poly) for reuse by the Chien-search stage.
- One natural sub-module, gf_alpha_lfsr: an M-bit alpha register with load-to-1 and step enable. It instantiates the package function and is the FILL datapath.

## Test plan
- Build time: release rst_n and count edges until ready rises. Required: 256 edges for M = 8, and 16 edges for M = 4 with PRIM_POLY = 5'h13.
- Log reads, M = 8, 0x11D, channel 0 mode 0: addr 1, 2, 3, 7, 255 -> rsp_data 0, 1, 25, 198, 175, each one cycle later.
- Antilog reads, mode 1: addr 0, 1, 8, 25, 255 -> rsp_data 1, 2, 29, 3, 1. The last value checks the wrap entry.
- Zero and channel independence: channel 0 log addr 0 together with channel 1 antilog addr 0 in the same cycle. Required: ch0 data 255 and ch1 data 1, with rsp_zero = 2'b01 under GF_ZERO_FLAG_EN.
- Early requests: drive req_valid high on all channels from reset release. Required: rsp_valid stays 0 through edge 256 and first goes high after edge 257.
- Mid-operation reset: pulse rst_n low during streaming reads. Required: rsp_valid and ready drop at once, rebuild takes 256 edges, and an exhaustive sweep afterwards shows log(alog(k)) = k for k = 0..254.
